char_rotator: RTL and testbench

Upstream control stage for the five-character seven-segment display path. Holds a five-character word of 3-bit character codes and rotates it across five display positions, one step per prescaler period or per single-step request. Each registered per-position code drives one 5-to-1 character multiplexer / seven-segment decoder instance downstream, producing a scrolling word on the display.

---
 rtl/char_rotator_pkg.sv | 58 +++++
 rtl/char_rotator_tick_prescaler.sv | 46 ++++
 rtl/char_rotator.sv | 182 ++++++++++++++++++
 tb/tb_char_rotator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/char_rotator_pkg.sv
// -----------------------------------------------------------------------------
// char_rotator_pkg
//
// Shared definitions for the five-character display rotator:
//   - default character code width and number of display positions
//   - rotation-offset width and its wrap limits
//   - FSM state encoding (STOP / RUN)
//   - mod-5 increment / decrement helpers and the position-to-character
//     index helper used by the output multiplexers
// -----------------------------------------------------------------------------
package char_rotator_pkg;

    // Default character code width.
    localparam int CW_DEFAULT = 3;

    // Number of characters in the word and number of display positions.
    localparam int NUM_POS = 5;

    // Offset register width; holds 0..NUM_POS-1.
    localparam int OFF_W = 3;

    // Offset wrap limits for the mod-5 counter.
    localparam logic [OFF_W-1:0] OFF_FIRST = 3'd0;
    localparam logic [OFF_W-1:0] OFF_LAST  = 3'd4;

    // Position count at index-sum width, used by the explicit wrap compare.
    localparam logic [OFF_W:0] POS_COUNT = 4'd5;

    // Rotation FSM: STOP waits for single steps, RUN advances on the prescaler.
    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Offset +1 mod 5 (4 wraps to 0).
    function automatic logic [OFF_W-1:0] off_inc(input logic [OFF_W-1:0] off);
        return (off == OFF_LAST) ? OFF_FIRST : off + 3'd1;
    endfunction

    // Offset -1 mod 5 (0 wraps to 4).
    function automatic logic [OFF_W-1:0] off_dec(input logic [OFF_W-1:0] off);
        return (off == OFF_FIRST) ? OFF_LAST : off - 3'd1;
    endfunction

    // Character index shown at display position 'pos' for rotation 'off':
    // (pos + off) mod 5. Both operands are below 5, so the sum is below 10
    // and a single conditional subtract replaces the modulo operator.
    function automatic logic [OFF_W-1:0] rot_index(input logic [OFF_W-1:0] pos,
                                                   input logic [OFF_W-1:0] off);
        logic [OFF_W:0] sum;
        sum = {1'b0, pos} + {1'b0, off};
        if (sum >= POS_COUNT) begin
            sum = sum - POS_COUNT;
        end
        return sum[OFF_W-1:0];
    endfunction

endpackage : char_rotator_pkg

// File: rtl/char_rotator_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//
// Free-running period counter for the rotator. While enabled it counts
// 0..TICK_DIV-1 and wraps; tc is high (combinationally) during the cycle in
// which the counter sits at its terminal value, so the owning block advances
// on the same edge that wraps the counter. A clear holds the counter at 0 and
// takes priority over counting.
//
// Ports:
//   clk    in  : system clock
//   rst_n  in  : asynchronous active-low reset
//   en     in  : count enable
//   clr    in  : synchronous clear (priority over en)
//   tc     out : terminal-count indication, qualified by en
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt;

    assign tc = en && (pcnt == LAST);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            pcnt <= tc ? '0 : pcnt + PW'(1);
        end
    end

endmodule : tick_prescaler

// File: rtl/char_rotator.sv
// -----------------------------------------------------------------------------
// char_rotator
//
// Control stage for the five-character seven-segment display. Stores a word
// of five CW-bit character codes and rotates it across the five display
// positions, either automatically once per TICK_DIV cycles (RUN) or once per
// step request (STOP). Each display output is registered and feeds one
// character multiplexer / seven-segment decoder downstream.
//
// Ports:
//   clk        in          : system clock
//   rst_n      in          : asynchronous active-low reset
//   load       in          : one-cycle request to capture load_data
//   load_data  in  5*CW    : new word; char0 in [CW-1:0], char4 in the top bits
//   run        in          : level, 1 = automatic rotation
//   dir        in          : 0 = rotate left (offset +1), 1 = right (offset -1)
//   step       in          : one-cycle single-step request, used only in STOP
//   disp0..4   out CW each : registered character code per display position
//   offset     out 3       : current rotation offset, 0..4
//   tick       out         : one-cycle pulse in the cycle the offset advanced
//
// Load wins over any coincident advance: it rewrites the word, returns the
// offset to 0, restarts the prescaler and suppresses tick. It does not touch
// the FSM state.
// -----------------------------------------------------------------------------
module char_rotator
    import char_rotator_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int CW       = CW_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [NUM_POS*CW-1:0] load_data,
    input  logic                  run,
    input  logic                  dir,
    input  logic                  step,
    output logic [CW-1:0]         disp0,
    output logic [CW-1:0]         disp1,
    output logic [CW-1:0]         disp2,
    output logic [CW-1:0]         disp3,
    output logic [CW-1:0]         disp4,
    output logic [OFF_W-1:0]      offset,
    output logic                  tick
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t            state;
    state_t            state_nx;

    logic [CW-1:0]     chars  [NUM_POS];
    logic [CW-1:0]     disp_q [NUM_POS];
    logic [OFF_W-1:0]  off_q;
    logic [OFF_W-1:0]  off_nx;
    logic              tick_q;

    // Prescaler control and advance qualification.
    logic              pres_en;
    logic              pres_clr;
    logic              tc;
    logic              adv;

    // -------------------------------------------------------------------------
    // Prescaler: counts only in RUN; held at 0 in STOP so that re-entering
    // RUN always waits a full period; restarted by load.
    // -------------------------------------------------------------------------
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pres_en),
        .clr   (pres_clr),
        .tc    (tc)
    );

    // -------------------------------------------------------------------------
    // FSM next state and control decode
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        pres_en  = 1'b0;
        pres_clr = load;
        adv      = 1'b0;
        off_nx   = off_q;

        unique case (state)
            ST_STOP: begin
                pres_clr = 1'b1;
                adv      = step;
                if (run) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                // step is ignored here; a terminal count still advances even
                // in the cycle run drops.
                pres_en = 1'b1;
                adv     = tc;
                if (!run) begin
                    state_nx = ST_STOP;
                end
            end
            default: begin
                state_nx = ST_STOP;
            end
        endcase

        // Load has priority over any advance event in the same cycle.
        if (load) begin
            adv = 1'b0;
        end

        // dir is only consulted here, i.e. at an advance event.
        if (adv) begin
            off_nx = dir ? off_dec(off_q) : off_inc(off_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_STOP;
        end else begin
            state <= state_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Word storage, offset and tick
    // -------------------------------------------------------------------------
    // NOTE: the five character registers are a small register array, not a
    // RAM, so they take the asynchronous reset like every other flop here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_POS; k++) begin
                chars[k] <= '0;
            end
            off_q  <= OFF_FIRST;
            tick_q <= 1'b0;
        end else begin
            tick_q <= adv;
            if (load) begin
                for (int k = 0; k < NUM_POS; k++) begin
                    chars[k] <= load_data[k*CW +: CW];
                end
                off_q <= OFF_FIRST;
            end else begin
                off_q <= off_nx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register: disp_k = char[(k + offset) mod 5], one cycle behind the
    // offset / word registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_POS; k++) begin
                disp_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_POS; k++) begin
                disp_q[k] <= chars[rot_index(OFF_W'(k), off_q)];
            end
        end
    end

    assign disp0  = disp_q[0];
    assign disp1  = disp_q[1];
    assign disp2  = disp_q[2];
    assign disp3  = disp_q[3];
    assign disp4  = disp_q[4];
    assign offset = off_q;
    assign tick   = tick_q;

endmodule : char_rotator

// File: tb/tb_char_rotator.sv
// -----------------------------------------------------------------------------
// tb_char_rotator
//
// Directed bench for char_rotator with TICK_DIV = 4, CW = 3. Stimulus pushes
// one expected record per tick (cycle of the tick, offset after it, and the
// display word one cycle later) into a queue; a monitor pops a record every
// time the DUT pulses tick and compares. Non-tick observations (reset values,
// load results, idle offsets) are checked inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_char_rotator;

    localparam int TD = 4;
    localparam int CWT = 3;

    typedef struct {
        int          cyc;
        logic [2:0]  off;
        logic [14:0] disp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [14:0] load_data;
    logic        run;
    logic        dir;
    logic        step;
    logic [2:0]  disp0, disp1, disp2, disp3, disp4;
    logic [2:0]  offset;
    logic        tick;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    char_rotator #(
        .TICK_DIV (TD),
        .CW       (CWT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .run       (run),
        .dir       (dir),
        .step      (step),
        .disp0     (disp0),
        .disp1     (disp1),
        .disp2     (disp2),
        .disp3     (disp3),
        .disp4     (disp4),
        .offset    (offset),
        .tick      (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Word seen on disp4..disp0 for a stored word w rotated by off.
    function automatic logic [14:0] rot_word(input logic [14:0] w, input int off);
        logic [14:0] r;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[k*3 +: 3] = w[((k + off) % 5)*3 +: 3];
        end
        return r;
    endfunction

    function automatic logic [14:0] disp_word();
        return {disp4, disp3, disp2, disp1, disp0};
    endfunction

    task automatic push(input int c, input int off, input logic [14:0] w);
        exp_t e;
        e.cyc  = c;
        e.off  = 3'(off);
        e.disp = rot_word(w, off);
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    // Monitor: compare every tick against the head of the expectation queue.
    // -------------------------------------------------------------------------
    initial begin : monitor
        logic        disp_pending;
        logic [14:0] disp_exp;
        exp_t        e;
        disp_pending = 1'b0;
        disp_exp     = '0;
        forever begin
            @(negedge clk);
            if (disp_pending) begin
                check("tick_disp", 32'(disp_word()), 32'(disp_exp));
                disp_pending = 1'b0;
            end
            if (tick === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_tick", 32'(tick), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("tick_cycle", 32'(cyc), 32'(e.cyc));
                    check("tick_offset", 32'(offset), 32'(e.off));
                    disp_exp     = e.disp;
                    disp_pending = 1'b1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin : stimulus
        logic [14:0] w1;
        logic [14:0] w2;
        int c0, c1, r0;

        w1 = 15'b100_011_010_001_000;
        w2 = {3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

        rst_n = 1'b0; load = 1'b0; load_data = '0;
        run = 1'b0; dir = 1'b0; step = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_disp", 32'(disp_word()), 32'd0);
        check("reset_offset", 32'(offset), 32'd0);
        check("reset_tick", 32'(tick), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: load and show unrotated.
        load = 1'b1; load_data = w1;
        @(negedge clk);
        load = 1'b0;
        check("load_offset", 32'(offset), 32'd0);
        @(negedge clk);
        check("load_disp", 32'(disp_word()), 32'h4688); // 0,1,2,3,4 on disp0..4

        // 2: run left; ticks every 4 cycles, full turn after 5.
        c0 = cyc;
        run = 1'b1; dir = 1'b0;
        for (int i = 1; i <= 5; i++) push(c0 + 1 + 4*i, i % 5, w1);
        wait_until(c0 + 22);
        step = 1'b1;                              // ignored in RUN
        @(negedge clk);
        step = 1'b0;
        check("step_in_run_offset", 32'(offset), 32'd0);

        // 3: stop, direction right, one step from offset 0 to 4.
        run = 1'b0; dir = 1'b1;
        wait_until(c0 + 26);
        check("stopped_offset", 32'(offset), 32'd0);
        step = 1'b1;
        push(c0 + 27, 4, w1);
        @(negedge clk);
        step = 1'b0;
        wait_until(c0 + 30);

        // 4: load coincident with the terminal count.
        c1 = cyc;
        run = 1'b1; dir = 1'b0;
        wait_until(c1 + 4);
        load = 1'b1; load_data = w2;
        push(c1 + 9, 1, w2);
        @(negedge clk);
        load = 1'b0;
        check("load_tc_tick", 32'(tick), 32'd0);
        check("load_tc_offset", 32'(offset), 32'd0);
        @(negedge clk);
        check("load_tc_disp", 32'(disp_word()), 32'(w2));

        // 5: drop run at pcnt = 2, idle 3 cycles, re-raise.
        wait_until(c1 + 11);
        run = 1'b0;
        wait_until(c1 + 14);
        check("idle_offset", 32'(offset), 32'd1);
        run = 1'b1;
        push(c1 + 19, 2, w2);
        push(c1 + 23, 3, w2);

        // 6: asynchronous reset mid-RUN at offset 3.
        wait_until(c1 + 24);
        check("pre_reset_offset", 32'(offset), 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_disp", 32'(disp_word()), 32'd0);
        check("async_reset_offset", 32'(offset), 32'd0);
        check("async_reset_tick", 32'(tick), 32'd0);
        run = 1'b0; dir = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r0 = cyc;
        step = 1'b1;                              // honoured only if back in STOP
        push(r0 + 1, 1, 15'd0);
        @(negedge clk);
        step = 1'b0;
        repeat (4) @(negedge clk);

        check("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_char_rotator
